// File: rtl/dwt_pkg.sv
// Shared widths, FSM encodings and floor-division helpers for the 5/3 row lifting stage.
package dwt_pkg;

  localparam int DW_DEF = 11;
  localparam int OW_DEF = 12;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Wide signed accumulator; sums never approach this range, so no intermediate wrap.
  typedef logic signed [31:0] acc_t;

  function automatic acc_t floor_half(input acc_t v);
    return v >>> 1;
  endfunction

  function automatic acc_t floor_quarter(input acc_t v);
    return v >>> 2;
  endfunction

endpackage

// File: rtl/dwt53_lift_pe.sv
// Combinational 5/3 predict + update for one (even, odd) pair.
module dwt53_lift_pe
  import dwt_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic [DW-1:0] e_cur,
  input  logic [DW-1:0] o_cur,
  input  logic [DW-1:0] e_next,
  input  logic [OW-1:0] d_prev,
  input  logic          use_dself,
  output logic [OW-1:0] d,
  output logic [OW-1:0] s
);

  acc_t e_c_s;
  acc_t o_c_s;
  acc_t e_n_s;
  acc_t d_p_s;
  acc_t d_w_s;
  acc_t s_w_s;
  logic unused_hi_s;

  // Predict then update; use_dself mirrors d[0] into d[-1] at the line start.
  always_comb begin
    e_c_s = acc_t'($signed(e_cur));
    o_c_s = acc_t'($signed(o_cur));
    e_n_s = acc_t'($signed(e_next));
    d_w_s = o_c_s - floor_half(e_c_s + e_n_s);
    if (use_dself) begin
      d_p_s = d_w_s;
    end else begin
      d_p_s = acc_t'($signed(d_prev));
    end
    s_w_s = e_c_s + floor_quarter(d_p_s + d_w_s + 32'sd2);
  end

  assign d           = d_w_s[OW-1:0];
  assign s           = s_w_s[OW-1:0];
  assign unused_hi_s = ^{d_w_s[31:OW], s_w_s[31:OW]};

endmodule

// File: rtl/dwt53_row_lift.sv
// Horizontal 5/3 reversible lifting over a framed stream of even/odd sample pairs,
// with symmetric extension at both line ends and one flush cycle per line.
module dwt53_row_lift
  import dwt_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          line_start,
  input  logic          line_end,
  input  logic [DW-1:0] even_in,
  input  logic [DW-1:0] odd_in,
  output logic          out_valid,
  output logic          out_first,
  output logic          out_last,
  output logic [OW-1:0] low_out,
  output logic [OW-1:0] high_out,
  output logic          seq_err
);

  logic [1:0]    st_q, st_d;
  logic [DW-1:0] e_q, e_d;
  logic [DW-1:0] o_q, o_d;
  logic [OW-1:0] dp_q, dp_d;
  logic          first_q, first_d;
  logic          out_valid_q, out_valid_d;
  logic          out_first_q, out_first_d;
  logic          out_last_q, out_last_d;
  logic [OW-1:0] low_q, low_d;
  logic [OW-1:0] high_q, high_d;
  logic          seq_err_q, seq_err_d;

  logic [DW-1:0] e_next_s;
  logic [OW-1:0] pe_d_s;
  logic [OW-1:0] pe_s_s;

  // In FLUSH the right neighbour is mirrored: x[2N] := x[2N-2].
  assign e_next_s = (st_q == ST_FLUSH) ? e_q : even_in;

  dwt53_lift_pe #(.DW(DW), .OW(OW)) u_pe (
    .e_cur     (e_q),
    .o_cur     (o_q),
    .e_next    (e_next_s),
    .d_prev    (dp_q),
    .use_dself (first_q),
    .d         (pe_d_s),
    .s         (pe_s_s)
  );

  // Framing FSM and next values of the output registers.
  always_comb begin
    st_d        = st_q;
    e_d         = e_q;
    o_d         = o_q;
    dp_d        = dp_q;
    first_d     = first_q;
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;
    low_d       = low_q;
    high_d      = high_q;
    seq_err_d   = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (in_valid && line_start) begin
          e_d     = even_in;
          o_d     = odd_in;
          first_d = 1'b1;
          st_d    = line_end ? ST_FLUSH : ST_RUN;
        end else if (in_valid) begin
          seq_err_d = 1'b1;
        end else begin
          st_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          if (line_start) begin
            seq_err_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_first_d = first_q;
            low_d       = pe_s_s;
            high_d      = pe_d_s;
            dp_d        = pe_d_s;
          end
          e_d     = even_in;
          o_d     = odd_in;
          first_d = line_start;
          st_d    = line_end ? ST_FLUSH : ST_RUN;
        end else begin
          st_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        out_valid_d = 1'b1;
        out_first_d = first_q;
        out_last_d  = 1'b1;
        low_d       = pe_s_s;
        high_d      = pe_d_s;
        first_d     = 1'b0;
        st_d        = ST_IDLE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, including mid-line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= ST_IDLE;
      e_q         <= '0;
      o_q         <= '0;
      dp_q        <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      low_q       <= '0;
      high_q      <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      e_q         <= e_d;
      o_q         <= o_d;
      dp_q        <= dp_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      low_q       <= low_d;
      high_q      <= high_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign in_ready  = (st_q != ST_FLUSH);
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign low_out   = low_q;
  assign high_out  = high_q;
  assign seq_err   = seq_err_q;

endmodule
